// File: rtl/video_sync_gen.sv
// rtl/video_sync_gen.sv - raster timing generator: h/v counters with registered sync, blank and pulse outputs.
// Optional VIDEO_SYNC_GEN_CSYNC_SERR_EN selects serrated composite sync (hs ^ vs) instead of hs | vs.
module video_sync_gen #(
  parameter int   HW       = 11,
  parameter int   VW       = 10,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          en,
  input  logic [HW-1:0] htotal,
  input  logic [HW-1:0] hact_end,
  input  logic [HW-1:0] hs_start,
  input  logic [HW-1:0] hs_end,
  input  logic [VW-1:0] vtotal,
  input  logic [VW-1:0] vact_end,
  input  logic [VW-1:0] vs_start,
  input  logic [VW-1:0] vs_end,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          csync,
  output logic          cblank,
  output logic          pclr,
  output logic          frame
);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hsync_q, vsync_q, csync_q, cblank_q, pclr_q, frame_q;
  logic          hwrap, hs, vs, cs, cblank_d, pclr_d, frame_d;

  always_comb begin
    // >= rather than == so a shrinking total pulls an overrun counter back at once
    hwrap  = (hcnt_q >= htotal);
    hcnt_d = hwrap ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hwrap) begin
      vcnt_d = (vcnt_q >= vtotal) ? '0 : vcnt_q + 1'b1;
    end
    hs       = (hcnt_q >= hs_start) && (hcnt_q < hs_end);
    vs       = (vcnt_q >= vs_start) && (vcnt_q < vs_end);
`ifdef VIDEO_SYNC_GEN_CSYNC_SERR_EN
    cs       = hs ^ vs;
`else
    cs       = hs | vs;
`endif
    cblank_d = (hcnt_q >= hact_end) || (vcnt_q >= vact_end);
    pclr_d   = (hcnt_q == htotal);
    frame_d  = pclr_d && (vcnt_q == vtotal);
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      hsync_q  <= SYNC_POL;
      vsync_q  <= SYNC_POL;
      csync_q  <= SYNC_POL;
      cblank_q <= 1'b1;
      pclr_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else if (en) begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      hsync_q  <= hs ^ SYNC_POL;
      vsync_q  <= vs ^ SYNC_POL;
      csync_q  <= cs ^ SYNC_POL;
      cblank_q <= cblank_d;
      pclr_q   <= pclr_d;
      frame_q  <= frame_d;
    end
  end

  assign hcnt   = hcnt_q;
  assign vcnt   = vcnt_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign csync  = csync_q;
  assign cblank = cblank_q;
  assign pclr   = pclr_q;
  assign frame  = frame_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// tb/tb_video_sync_gen.sv - randomized and directed bench for video_sync_gen against a raster-position model.
// Expected csync follows VIDEO_SYNC_GEN_CSYNC_SERR_EN when the bench is built with it.
module tb_video_sync_gen;

  localparam int HW = 11;
  localparam int VW = 10;

  logic          CK = 1'b0;
  logic          RST = 1'b1;
  logic          en = 1'b0;
  logic [HW-1:0] htotal, hact_end, hs_start, hs_end;
  logic [VW-1:0] vtotal, vact_end, vs_start, vs_end;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [VW-1:0] vcnt, vcnt_n;
  logic          hsync, vsync, csync, cblank, pclr, frame;
  logic          hsync_n, vsync_n, csync_n, cblank_n, pclr_n, frame_n;

  always #5 CK = ~CK;

  video_sync_gen #(.HW(HW), .VW(VW), .SYNC_POL(1'b0)) u_dut (
    .CK(CK), .RST(RST), .en(en),
    .htotal(htotal), .hact_end(hact_end), .hs_start(hs_start), .hs_end(hs_end),
    .vtotal(vtotal), .vact_end(vact_end), .vs_start(vs_start), .vs_end(vs_end),
    .hcnt(hcnt), .vcnt(vcnt), .hsync(hsync), .vsync(vsync), .csync(csync),
    .cblank(cblank), .pclr(pclr), .frame(frame)
  );

  video_sync_gen #(.HW(HW), .VW(VW), .SYNC_POL(1'b1)) u_dut_n (
    .CK(CK), .RST(RST), .en(en),
    .htotal(htotal), .hact_end(hact_end), .hs_start(hs_start), .hs_end(hs_end),
    .vtotal(vtotal), .vact_end(vact_end), .vs_start(vs_start), .vs_end(vs_end),
    .hcnt(hcnt_n), .vcnt(vcnt_n), .hsync(hsync_n), .vsync(vsync_n), .csync(csync_n),
    .cblank(cblank_n), .pclr(pclr_n), .frame(frame_n)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: raster position (col, line) and the pixel attributes latched at the last enabled edge
  int m_h, m_v;
  bit m_hs, m_vs, m_cs, m_cb, m_pclr, m_frame;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_win(input int x, input int s, input int e);
    return (x >= s) && (x < e);
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0;
    m_hs = 0; m_vs = 0; m_cs = 0; m_cb = 1; m_pclr = 0; m_frame = 0;
  endtask

  task automatic model_step();
    m_hs = in_win(m_h, int'(hs_start), int'(hs_end));
    m_vs = in_win(m_v, int'(vs_start), int'(vs_end));
`ifdef VIDEO_SYNC_GEN_CSYNC_SERR_EN
    m_cs = m_hs ^ m_vs;
`else
    m_cs = m_hs | m_vs;
`endif
    m_cb    = (m_h >= int'(hact_end)) || (m_v >= int'(vact_end));
    m_pclr  = (m_h == int'(htotal));
    m_frame = m_pclr && (m_v == int'(vtotal));
    if (m_h >= int'(htotal)) begin
      m_h = 0;
      m_v = (m_v >= int'(vtotal)) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
  endtask

  task automatic check_all();
    check("hcnt",     32'(hcnt),    32'(m_h));
    check("vcnt",     32'(vcnt),    32'(m_v));
    check("hsync",    32'(hsync),   32'(m_hs));
    check("vsync",    32'(vsync),   32'(m_vs));
    check("csync",    32'(csync),   32'(m_cs));
    check("cblank",   32'(cblank),  32'(m_cb));
    check("pclr",     32'(pclr),    32'(m_pclr));
    check("frame",    32'(frame),   32'(m_frame));
    check("hsync_n",  32'(hsync_n), 32'(!m_hs));
    check("vsync_n",  32'(vsync_n), 32'(!m_vs));
    check("csync_n",  32'(csync_n), 32'(!m_cs));
  endtask

  // Called at a falling edge: drive en, advance the model over the next rising edge, check at the next falling edge
  task automatic tick(input logic e);
    en = e;
    if (e) model_step();
    @(negedge CK);
    check_all();
  endtask

  task automatic do_reset();
    #2 RST = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge CK);
    check_all();
    RST = 1'b0;
  endtask

  task automatic cfg_ref();
    htotal = 9; hact_end = 6; hs_start = 7; hs_end = 9;
    vtotal = 4; vact_end = 3; vs_start = 3; vs_end = 4;
  endtask

  int cnt_p, cnt_f, cnt_s, guard;

  initial begin
    cfg_ref();
    model_reset();
    @(negedge CK);
    check_all();
    RST = 1'b0;

    // Reference timing, continuous enable: pulse rates over 100 pixels
    cnt_p = 0; cnt_f = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b1);
      cnt_p += int'(pclr);
      cnt_f += int'(frame);
    end
    check("pclr_rate_en1", 32'(cnt_p), 32'd10);
    check("frame_rate_en1", 32'(cnt_f), 32'd2);

    // Alternating enable: 200 clocks carry 100 pixels
    do_reset();
    cnt_p = 0; cnt_f = 0;
    for (int i = 0; i < 200; i++) begin
      tick(i[0] ? 1'b0 : 1'b1);
      if (i[0] == 1'b0) begin
        cnt_p += int'(pclr);
        cnt_f += int'(frame);
      end
    end
    check("pclr_rate_alt", 32'(cnt_p), 32'd10);
    check("frame_rate_alt", 32'(cnt_f), 32'd2);

    // Shrink htotal below the current column
    guard = 0;
    while (m_h != 8 && guard < 100) begin
      tick(1'b1);
      guard++;
    end
    check("reach_h8", 32'(m_h), 32'd8);
    htotal = 5;
    tick(1'b1);
    check("shrink_pclr", 32'(pclr), 32'd0);
    check("shrink_hcnt", 32'(hcnt), 32'd0);
    for (int i = 0; i < 30; i++) tick(1'b1);
    cfg_ref();

    // Asynchronous reset mid-frame, then resume from column 1
    guard = 0;
    while (!(m_h == 5 && m_v == 2) && guard < 200) begin
      tick(1'b1);
      guard++;
    end
    check("reach_h5v2", 32'(m_h * 16 + m_v), 32'(5 * 16 + 2));
    do_reset();
    tick(1'b1);
    check("post_reset_hcnt", 32'(hcnt), 32'd1);

    // Degenerate sync windows over two frames
    hs_start = 4; hs_end = 4; vs_start = 5; vs_end = 2;
    do_reset();
    cnt_s = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b1);
      cnt_s += int'(hsync) + int'(vsync);
    end
    check("empty_windows", 32'(cnt_s), 32'd0);

    // htotal = 0: column pinned, line advances each pixel
    htotal = 0; vtotal = 3;
    for (int i = 0; i < 12; i++) tick(1'b1);

    // Random timing, enable and occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        htotal   = HW'($urandom_range(0, 12));
        hact_end = HW'($urandom_range(0, 13));
        hs_start = HW'($urandom_range(0, 13));
        hs_end   = HW'($urandom_range(0, 13));
        vtotal   = VW'($urandom_range(0, 6));
        vact_end = VW'($urandom_range(0, 7));
        vs_start = VW'($urandom_range(0, 7));
        vs_end   = VW'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      tick($urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
